apb_master_ctrl: RTL

//  APB requester. Turns single-beat requests from the system side into APB transfers
//  (SETUP then ACCESS) toward the APB_Slave_with_mem targets, one transfer at a time.

---
 rtl/apb_pkg.sv | 22 ++
 rtl/apb_master_ctrl_if.sv | 37 +++
 rtl/apb_wait_timer.sv | 40 ++++
 rtl/apb_master_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared types for the APB requester slice.
// Combinational only, no latency.
// No flow control; types and defaults only.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  localparam int APB_AW  = 8;
  localparam int APB_DW  = 8;
  localparam int APB_IDW = 2;

  // Response as seen by the requester: read data plus error flag.
  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              err;
  } apb_rsp_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// Request/response and APB bus bundle for apb_master_ctrl.
// Wires only, no latency.
// req_ready gates requests; responses have no backpressure.
interface apb_master_ctrl_if
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int AW         = APB_AW,
  parameter int DW         = APB_DW
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [APB_IDW-1:0]    req_id;
  logic [AW-1:0]         req_addr;
  logic [DW-1:0]         req_wdata;
  logic                  rsp_valid;
  logic [DW-1:0]         rsp_rdata;
  logic                  rsp_err;
  logic [NUM_SLAVES-1:0] sel;
  logic                  enable;
  logic                  write;
  logic [AW-1:0]         addr;
  logic [DW-1:0]         wdata;
  logic [DW-1:0]         rdata;
  logic                  ready;

  modport master (
    input  req_valid, req_write, req_id, req_addr, req_wdata, rdata, ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, write, addr, wdata
  );

  modport slave (
    output req_valid, req_write, req_id, req_addr, req_wdata, rdata, ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, sel, enable, write, addr, wdata
  );
endinterface

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS cycles spent with ready low.
// expired_o is combinational on the increment that reaches TIMEOUT.
// No flow control; TIMEOUT=0 never expires.
module apb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the wait cycle whose increment brings the count up to TIMEOUT.
  assign expired_o = (TIMEOUT != 0) && inc_i && ((int'(cnt_q) + 1) >= TIMEOUT);

endmodule

// File: rtl/apb_master_ctrl.sv
// APB requester: one request in, SETUP+ACCESS on the bus, one response out.
// Zero wait states: accept at N, rsp_valid in N+3; each wait state adds one cycle.
// req_ready is high only in IDLE; responses are never stalled.
module apb_master_ctrl
  import apb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int TIMEOUT    = 16,
  parameter int AW         = APB_AW,
  parameter int DW         = APB_DW
) (
  input  logic              clk,
  input  logic              reset,
  apb_master_ctrl_if.master bus
);
  apb_state_t            state_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] sel_d;
  logic                  enable_q;
  logic                  write_q;
  logic [AW-1:0]         addr_q;
  logic [DW-1:0]         wdata_q;
  logic                  rsp_valid_q;
  logic [DW-1:0]         rsp_rdata_q;
  logic                  rsp_err_q;
  logic                  id_ok;
  logic                  tmr_clear;
  logic                  tmr_inc;
  logic                  tmr_expired;

  // One-hot select for the requested target; all zero for an out-of-range id.
  always_comb begin
    sel_d = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_d[i] = (int'(bus.req_id) == i);
    end
  end

  assign id_ok     = (int'(bus.req_id) < NUM_SLAVES);
  assign tmr_clear = (state_q == SETUP);
  assign tmr_inc   = (state_q == ACCESS) && !bus.ready;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (tmr_clear),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  // Transfer FSM with registered bus and response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      enable_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (id_ok) begin
              state_q <= SETUP;
              sel_q   <= sel_d;
              write_q <= bus.req_write;
              addr_q  <= bus.req_addr;
              wdata_q <= bus.req_wdata;
            end else begin
              // Bad target: answer with an error straight from IDLE, bus untouched.
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        SETUP: begin
          state_q  <= ACCESS;
          enable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.ready) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= write_q ? '0 : bus.rdata;
          end else if (tmr_expired) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            enable_q    <= 1'b0;
            write_q     <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.sel       = sel_q;
  assign bus.enable    = enable_q;
  assign bus.write     = write_q;
  assign bus.addr      = addr_q;
  assign bus.wdata     = wdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
